// File: rtl/front_panel_seq_if.sv
// rtl/front_panel_seq_if.sv - panel-to-memory request/acknowledge bus
// The sequencer drives the request side; memory acks and returns read data in the same cycle.
interface front_panel_seq_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/front_panel_seq.sv
// rtl/front_panel_seq.sv - Altair front-panel sequencer: panel buttons to bus transactions
// Optional held-button auto-repeat for examine-next/deposit-next: FP_AUTOREPEAT_EN.
module front_panel_seq #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  examine_pb,
  input  logic                  examine_next_pb,
  input  logic                  deposit_pb,
  input  logic                  deposit_next_pb,
  input  logic                  reset_pb,
  input  logic                  step_pb,
  input  logic                  examine_next_held,
  input  logic                  deposit_next_held,
  input  logic [ADDR_WIDTH-1:0] addr_sw,
  input  logic [DATA_WIDTH-1:0] data_sw,
  front_panel_seq_if.master     bus,
  output logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  busy,
  output logic                  panel_own,
  output logic                  cpu_reset,
  output logic                  cpu_step
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t                r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nx;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nx;
  logic [DATA_WIDTH-1:0] r_disp_data, w_disp_data_nx;
  logic                  r_mem_req, w_mem_req_nx;
  logic                  r_mem_we, w_mem_we_nx;
  logic                  r_cpu_reset, w_cpu_reset_nx;
  logic                  r_cpu_step, w_cpu_step_nx;
  logic                  r_busy, r_panel_own;
  logic                  w_take_exn, w_take_dpn;
  logic [1:0]            w_rep;
  logic                  w_go_dep, w_go_dpn, w_go_exm, w_go_exn, w_go_stp;

  assign w_addr_inc = r_addr + ADDR_WIDTH'(1'b1);

  // Everything except reset is ignored while the CPU runs.
  assign w_go_dep = pause & deposit_pb;
  assign w_go_dpn = pause & (deposit_next_pb | w_rep[1]);
  assign w_go_exm = pause & examine_pb;
  assign w_go_exn = pause & (examine_next_pb | w_rep[0]);
  assign w_go_stp = pause & step_pb;

  always_comb begin
    w_state_nx     = r_state;
    w_addr_nx      = r_addr;
    w_mem_req_nx   = r_mem_req;
    w_mem_we_nx    = r_mem_we;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_disp_data_nx = r_disp_data;
    w_cpu_reset_nx = 1'b0;
    w_cpu_step_nx  = 1'b0;
    w_take_exn     = 1'b0;
    w_take_dpn     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reset_pb) begin
          w_cpu_reset_nx = 1'b1;
          if (pause) begin
            w_addr_nx     = '0;
            w_mem_addr_nx = '0;
            w_mem_req_nx  = 1'b1;
            w_mem_we_nx   = 1'b0;
            w_state_nx    = S_READ;
          end
        end else if (w_go_dep) begin
          w_mem_addr_nx  = r_addr;
          w_mem_wdata_nx = data_sw;
          w_mem_req_nx   = 1'b1;
          w_mem_we_nx    = 1'b1;
          w_state_nx     = S_WRITE;
        end else if (w_go_dpn) begin
          w_addr_nx      = w_addr_inc;
          w_mem_addr_nx  = w_addr_inc;
          w_mem_wdata_nx = data_sw;
          w_mem_req_nx   = 1'b1;
          w_mem_we_nx    = 1'b1;
          w_state_nx     = S_WRITE;
          w_take_dpn     = 1'b1;
        end else if (w_go_exm) begin
          w_addr_nx     = addr_sw;
          w_mem_addr_nx = addr_sw;
          w_mem_req_nx  = 1'b1;
          w_mem_we_nx   = 1'b0;
          w_state_nx    = S_READ;
        end else if (w_go_exn) begin
          w_addr_nx     = w_addr_inc;
          w_mem_addr_nx = w_addr_inc;
          w_mem_req_nx  = 1'b1;
          w_mem_we_nx   = 1'b0;
          w_state_nx    = S_READ;
          w_take_exn    = 1'b1;
        end else if (w_go_stp) begin
          w_cpu_step_nx = 1'b1;
        end
      end
      S_WRITE: begin
        // Request stays up into the read-back; only the direction flips.
        if (bus.mem_ack) begin
          w_mem_we_nx = 1'b0;
          w_state_nx  = S_READ;
        end
      end
      S_READ: begin
        if (bus.mem_ack) begin
          w_mem_req_nx   = 1'b0;
          w_disp_data_nx = bus.mem_rdata;
          w_state_nx     = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_disp_data <= '0;
      r_cpu_reset <= 1'b0;
      r_cpu_step  <= 1'b0;
      r_busy      <= 1'b0;
      r_panel_own <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_addr      <= w_addr_nx;
      r_mem_req   <= w_mem_req_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_disp_data <= w_disp_data_nx;
      r_cpu_reset <= w_cpu_reset_nx;
      r_cpu_step  <= w_cpu_step_nx;
      r_busy      <= (w_state_nx != S_IDLE);
      r_panel_own <= pause | (w_state_nx != S_IDLE);
    end
  end

`ifdef FP_AUTOREPEAT_EN
  localparam int CW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

  logic [1:0] w_held, w_press, w_take;

  assign w_held  = {deposit_next_held, examine_next_held};
  assign w_press = {deposit_next_pb, examine_next_pb};
  assign w_take  = {w_take_dpn, w_take_exn};

  // Channel 0 repeats examine-next, channel 1 deposit-next.
  for (genvar g = 0; g < 2; g++) begin : g_rep
    logic          r_armed, r_rpt, r_pend, w_fire;
    logic [CW-1:0] r_cnt, w_limit;

    assign w_limit = r_rpt ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1);
    assign w_fire  = pause & ~w_press[g] & w_held[g] & r_armed & (r_cnt == w_limit);

    always_ff @(posedge clk) begin
      if (reset || !pause) begin
        r_armed <= 1'b0;
        r_rpt   <= 1'b0;
        r_cnt   <= '0;
      end else if (w_press[g]) begin
        r_armed <= 1'b1;
        r_rpt   <= 1'b0;
        r_cnt   <= '0;
      end else if (!w_held[g]) begin
        r_armed <= 1'b0;
        r_rpt   <= 1'b0;
        r_cnt   <= '0;
      end else if (r_armed) begin
        if (w_fire) begin
          r_rpt <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1'b1);
        end
      end

      // A fired repeat waits here until the sequencer is free to take it.
      if (reset || !pause)
        r_pend <= 1'b0;
      else if (w_fire)
        r_pend <= 1'b1;
      else if (w_take[g])
        r_pend <= 1'b0;
    end

    assign w_rep[g] = r_pend;
  end
`else
  logic w_unused_rep;

  assign w_rep        = 2'b00;
  assign w_unused_rep = ^{examine_next_held, deposit_next_held, w_take_exn, w_take_dpn,
                          REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign disp_addr     = r_addr;
  assign disp_data     = r_disp_data;
  assign busy          = r_busy;
  assign panel_own     = r_panel_own;
  assign cpu_reset     = r_cpu_reset;
  assign cpu_step      = r_cpu_step;

endmodule

// File: tb/tb_front_panel_seq.sv
// tb/tb_front_panel_seq.sv - randomized self-checking bench for front_panel_seq
// Command-level reference model plus a memory responder with random wait states.
module tb_front_panel_seq;
  localparam int AW = 16;
  localparam int DW = 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            w;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          pause;
  logic          examine_pb, examine_next_pb, deposit_pb, deposit_next_pb, reset_pb, step_pb;
  logic          examine_next_held, deposit_next_held;
  logic [AW-1:0] addr_sw;
  logic [DW-1:0] data_sw;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          busy, panel_own, cpu_reset, cpu_step;

  front_panel_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  front_panel_seq #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause),
    .examine_pb(examine_pb), .examine_next_pb(examine_next_pb),
    .deposit_pb(deposit_pb), .deposit_next_pb(deposit_next_pb),
    .reset_pb(reset_pb), .step_pb(step_pb),
    .examine_next_held(examine_next_held), .deposit_next_held(deposit_next_held),
    .addr_sw(addr_sw), .data_sw(data_sw), .bus(bus),
    .disp_addr(disp_addr), .disp_data(disp_data), .busy(busy),
    .panel_own(panel_own), .cpu_reset(cpu_reset), .cpu_step(cpu_step)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] phys_mem [65536];
  logic [DW-1:0] ref_mem  [65536];
  txn_t          obs_q[$];
  txn_t          exp_q[$];
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_disp = '0;

  // Memory responder: random wait states per transaction, ack with data in the same cycle.
  int            wmin = 0, wmax = 0, wleft = -1, cur_w = 0;
  logic [AW-1:0] st_a;
  logic [DW-1:0] st_d;
  logic          st_we;
  initial begin
    txn_t t;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && reset === 1'b0) begin
        if (wleft < 0) begin
          wleft = $urandom_range(wmax, wmin);
          cur_w = wleft;
          st_a  = bus.mem_addr;
          st_d  = bus.mem_wdata;
          st_we = bus.mem_we;
        end
        if (wleft == 0) begin
          check_val("stable_addr", bus.mem_addr, st_a);
          check_val("stable_we", bus.mem_we, st_we);
          if (st_we) check_val("stable_wdata", bus.mem_wdata, st_d);
          t.we = bus.mem_we;
          t.a  = bus.mem_addr;
          t.w  = cur_w;
          if (bus.mem_we) begin
            phys_mem[bus.mem_addr] = bus.mem_wdata;
            t.d = bus.mem_wdata;
          end else begin
            t.d = phys_mem[bus.mem_addr];
          end
          bus.mem_rdata = phys_mem[bus.mem_addr];
          bus.mem_ack   = 1'b1;
          obs_q.push_back(t);
          wleft = -1;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = DW'($urandom);
          wleft--;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wleft       = -1;
      end
    end
  end

  int n_rst = 0, n_stp = 0;
  initial forever begin
    @(negedge clk);
    if (cpu_reset === 1'b1) n_rst++;
    if (cpu_step === 1'b1) n_stp++;
  end

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = 1'b1; t.a = a; t.d = d; t.w = 0;
    ref_mem[a] = d;
    exp_q.push_back(t);
  endtask

  task automatic push_read(input logic [AW-1:0] a);
    txn_t t;
    t.we = 1'b0; t.a = a; t.d = ref_mem[a]; t.w = 0;
    m_disp = ref_mem[a];
    exp_q.push_back(t);
  endtask

  // pbs = {reset, deposit, deposit_next, examine, examine_next, step}, highest bit wins.
  // inj_kind 1: pulse examine while busy; 2: drop pause mid-transaction.
  task automatic do_cmd(input logic [5:0] pbs, input logic p, input logic [AW-1:0] asw,
                        input logic [DW-1:0] dsw, input int inj_at, input int inj_kind);
    int   sel, k, exp_k;
    logic own_ok, exp_rst, exp_stp;
    @(negedge clk);
    pause   = p;
    addr_sw = asw;
    data_sw = dsw;
    {reset_pb, deposit_pb, deposit_next_pb, examine_pb, examine_next_pb, step_pb} = pbs;
    n_rst = 0;
    n_stp = 0;
    obs_q.delete();
    exp_q.delete();
    sel = -1;
    for (int i = 5; i >= 0; i--)
      if (sel < 0 && pbs[i] && (p || i == 5)) sel = i;
    exp_rst = (sel == 5);
    exp_stp = (sel == 0);
    if (p) begin
      case (sel)
        5: begin m_addr = '0; push_read(m_addr); end
        4: begin push_write(m_addr, dsw); push_read(m_addr); end
        3: begin m_addr = m_addr + 1'b1; push_write(m_addr, dsw); push_read(m_addr); end
        2: begin m_addr = asw; push_read(m_addr); end
        1: begin m_addr = m_addr + 1'b1; push_read(m_addr); end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    {reset_pb, deposit_pb, deposit_next_pb, examine_pb, examine_next_pb, step_pb} = 6'b0;
    check_val("req_n1", bus.mem_req, exp_q.size() > 0);
    check_val("disp_addr_n1", disp_addr, m_addr);
    if (exp_q.size() > 0) check_val("mem_addr_n1", bus.mem_addr, exp_q[0].a);
    check_val("cpu_reset_n1", cpu_reset, exp_rst);
    check_val("cpu_step_n1", cpu_step, exp_stp);
    k = 1;
    own_ok = 1'b1;
    while (busy === 1'b1 && k < 400) begin
      if (panel_own !== 1'b1) own_ok = 1'b0;
      examine_pb = 1'b0;
      if (k == inj_at && inj_kind == 1) examine_pb = 1'b1;
      if (k == inj_at && inj_kind == 2) pause = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    examine_pb = 1'b0;
    @(negedge clk); #1;
    exp_k = 1;
    if (exp_q.size() > 0)
      foreach (obs_q[i]) exp_k += obs_q[i].w + 1;
    check_val("busy_latency", k, exp_k);
    check_val("n_txn", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check_val("txn_we", obs_q[i].we, exp_q[i].we);
      check_val("txn_addr", obs_q[i].a, exp_q[i].a);
      check_val("txn_data", obs_q[i].d, exp_q[i].d);
    end
    check_val("disp_addr", disp_addr, m_addr);
    check_val("disp_data", disp_data, m_disp);
    check_val("n_cpu_reset", n_rst, exp_rst);
    check_val("n_cpu_step", n_stp, exp_stp);
    check_val("own_while_busy", own_ok, 1'b1);
    check_val("own_idle", panel_own, pause);
  endtask

  task automatic autorep_test();
    int            nexp;
    logic [AW-1:0] a0, ea;
    wmin = 0;
    wmax = 0;
    @(negedge clk);
    pause = 1'b1;
    obs_q.delete();
    a0 = m_addr;
    examine_next_pb   = 1'b1;
    examine_next_held = 1'b1;
    @(posedge clk); #1;
    examine_next_pb = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    examine_next_held = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
`ifdef FP_AUTOREPEAT_EN
    nexp = 6;
`else
    nexp = 1;
`endif
    check_val("rep_count", obs_q.size(), nexp);
    for (int i = 0; i < obs_q.size() && i < nexp; i++) begin
      ea = a0 + AW'(i + 1);
      check_val("rep_addr", obs_q[i].a, ea);
      check_val("rep_we", obs_q[i].we, 1'b0);
      check_val("rep_data", obs_q[i].d, ref_mem[ea]);
    end
    m_addr = a0 + AW'(nexp);
    m_disp = ref_mem[m_addr];
    check_val("rep_disp_addr", disp_addr, m_addr);
    check_val("rep_disp_data", disp_data, m_disp);
    check_val("rep_busy", busy, 1'b0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    logic [5:0]    pbs;
    int            kind;
    for (int i = 0; i < 65536; i++) begin
      v = DW'($urandom);
      phys_mem[i] = v;
      ref_mem[i]  = v;
    end
    phys_mem[16'h1234] = 8'hA5;
    ref_mem[16'h1234]  = 8'hA5;

    reset = 1'b1; pause = 1'b1;
    {reset_pb, deposit_pb, deposit_next_pb, examine_pb, examine_next_pb, step_pb} = 6'b0;
    examine_next_held = 1'b0; deposit_next_held = 1'b0;
    addr_sw = '0; data_sw = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req", bus.mem_req, 1'b0);
    check_val("rst_we", bus.mem_we, 1'b0);
    check_val("rst_mem_addr", bus.mem_addr, 0);
    check_val("rst_wdata", bus.mem_wdata, 0);
    check_val("rst_disp_addr", disp_addr, 0);
    check_val("rst_disp_data", disp_data, 0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_own", panel_own, 1'b0);
    check_val("rst_cpu_reset", cpu_reset, 1'b0);
    check_val("rst_cpu_step", cpu_step, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("own_after_rst", panel_own, 1'b1);

    do_cmd(6'b000100, 1'b1, 16'h1234, 8'h00, 0, 0);
    do_cmd(6'b000100, 1'b1, 16'hFFFF, 8'h00, 0, 0);
    do_cmd(6'b000010, 1'b1, 16'h0000, 8'h00, 0, 0);
    do_cmd(6'b010000, 1'b1, 16'h0000, 8'h5A, 0, 0);
    do_cmd(6'b000100, 1'b1, 16'h0010, 8'h00, 0, 0);
    wmin = 3; wmax = 3;
    do_cmd(6'b001000, 1'b1, 16'h0000, 8'h3C, 0, 0);
    wmin = 0; wmax = 0;
    do_cmd(6'b010100, 1'b1, 16'h4321, 8'h77, 0, 0);
    wmin = 2; wmax = 2;
    do_cmd(6'b010000, 1'b1, 16'h0000, 8'h11, 2, 1);
    do_cmd(6'b000100, 1'b0, 16'h2222, 8'h00, 0, 0);
    do_cmd(6'b000101, 1'b0, 16'h2222, 8'h00, 0, 0);
    do_cmd(6'b100000, 1'b0, 16'h0000, 8'h00, 0, 0);
    do_cmd(6'b100000, 1'b1, 16'h0000, 8'h00, 0, 0);
    do_cmd(6'b000001, 1'b1, 16'h0000, 8'h00, 0, 0);
    wmin = 3; wmax = 3;
    do_cmd(6'b000100, 1'b1, 16'h0abc, 8'h00, 1, 2);

    autorep_test();

    for (int n = 0; n < 150; n++) begin
      wmin = 0;
      wmax = $urandom_range(3, 0);
      if ($urandom_range(3, 0) == 0) pbs = 6'($urandom);
      else pbs = 6'b1 << $urandom_range(5, 0);
      kind = $urandom_range(5, 0);
      do_cmd(pbs, ($urandom_range(7, 0) != 0), AW'($urandom), DW'($urandom),
             $urandom_range(4, 1), (kind == 0) ? 1 : ((kind == 1) ? 2 : 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/front_panel_seq.md
# front_panel_seq

Parametrised front-panel sequencer for the Altair system. It turns debounced panel-button pulses into memory-bus transactions: examine, examine-next, deposit, deposit-next, reset and single-step. While the CPU is paused it acts as a direct bus master with a request/acknowledge handshake, so no instructions are jammed into the CPU. It holds the panel address register and drives the address/data LED values.

## Interface
- ADDR_WIDTH, 16, memory address width; the address register wraps modulo 2^ADDR_WIDTH
- DATA_WIDTH, 8, memory data width
- REPEAT_DELAY, 12_500_000, cycles a held next-button must stay high before auto-repeat starts
- REPEAT_PERIOD, 2_500_000, cycles between auto-repeat commands
---
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pause  in  1  1 = CPU stopped; panel may own the bus
- examine_pb, examine_next_pb, deposit_pb, deposit_next_pb, reset_pb, step_pb  in  1 each  one-cycle press pulses from the debouncers
- examine_next_held, deposit_next_held  in  1 each  debounced button levels, used for auto-repeat
- addr_sw  in  ADDR_WIDTH  address switches
- data_sw  in  DATA_WIDTH  data switches
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  transaction address
- mem_wdata  out  DATA_WIDTH  write data
- mem_ack  in  1  memory accepted or completed the transaction; read data is valid in the same cycle
- mem_rdata  in  DATA_WIDTH  read data
- disp_addr  out  ADDR_WIDTH  address register, for the LEDs
- disp_data  out  DATA_WIDTH  last read data, for the LEDs
- busy  out  1  sequencer not in IDLE
- panel_own  out  1  pause | busy; the bus mux selects the panel when this is 1
- cpu_reset  out  1  one-cycle CPU reset pulse
- cpu_step  out  1  one-cycle CPU clock-enable pulse

## Operation
- States: IDLE, WRITE, READ. All outputs are registered.
- Commands are accepted only in IDLE; a pulse that arrives while busy=1 is dropped. If several pulses arrive in the same cycle, priority is reset > deposit > deposit_next > examine > examine_next > step; the lower-priority pulses are dropped.
- When pause=0, every command except reset_pb is ignored. In that case reset_pb pulses cpu_reset only and issues no read.
- Command actions, with pause=1:
  - examine: addr_reg <= addr_sw, then READ.
  - examine_next: addr_reg <= addr_reg+1, then READ.
  - deposit: WRITE data_sw to addr_reg, then READ the same address (read-back).
  - deposit_next: addr_reg <= addr_reg+1, WRITE data_sw there, then READ.
  - reset: cpu_reset=1 for one cycle, addr_reg <= 0, then READ.
  - step: cpu_step=1 for one cycle; no bus transaction and busy stays 0.
- Address arithmetic is modulo 2^ADDR_WIDTH: all-ones + 1 = 0.
- WRITE: mem_req=1 and mem_we=1, with mem_addr and mem_wdata held stable until mem_ack is sampled high; then go to READ.
- READ: mem_req=1 and mem_we=0, held until mem_ack is sampled high; disp_data <= mem_rdata; then go to IDLE.
- If pause drops mid-transaction, the transaction in flight still completes; panel_own stays 1 until IDLE.
- Reset values: state IDLE; addr_reg 0; disp_data 0; mem_req, mem_we, busy, cpu_reset, cpu_step 0; mem_addr 0; mem_wdata 0; panel_own 0 for the first cycle after reset, then follows pause.

## Timing
- Command pulse in cycle N: mem_req=1 and disp_addr updated in cycle N+1.
- mem_ack sampled high in cycle M: mem_req low in M+1 for READ, or mem_req stays 1 with mem_we=0 in M+1 when going WRITE→READ. In the READ case disp_data is valid and busy=0 in M+1.
- With a zero-wait memory (ack in the first request cycle):
  - examine command to busy=0 takes 2 cycles.
  - deposit command to busy=0 takes 3 cycles.
- cpu_reset and cpu_step are high exactly in cycle N+1.
- A new command can be accepted in the cycle busy returns to 0.

## Configuration
- FP_AUTOREPEAT_EN defined:
  - Once examine_next_held or deposit_next_held has stayed high for REPEAT_DELAY cycles after its press pulse, the sequencer issues the matching command internally every REPEAT_PERIOD cycles while the level stays high and pause=1.
  - An internal command arriving while busy is deferred, not dropped.
  - The counter clears when the level falls, pause falls, or reset is asserted.
- FP_AUTOREPEAT_EN undefined: the held inputs are ignored and no repeat counter is built.

## Test plan
- Examine: pause=1, addr_sw=0x1234, memory[0x1234]=0xA5, pulse examine_pb → disp_addr=0x1234 next cycle; one read; disp_data=0xA5.
- Examine-next wrap: addr_reg=0xFFFF, pulse examine_next_pb → mem_addr=0x0000 and disp_addr=0x0000.
- Deposit-next with 3 wait states: addr_reg=0x0010, data_sw=0x3C → write 0x3C at 0x0011; mem_addr/mem_wdata stable for all 4 request cycles; read-back gives disp_data=0x3C.
- Arbitration: deposit_pb and examine_pb pulsed together → deposit only. examine_pb pulsed while busy → dropped, exactly one transaction.
- Run mode: pause=0, examine_pb and step_pb pulsed → no mem_req, no cpu_step. reset_pb → cpu_reset high 1 cycle, no mem_req.
- FP_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4: examine_next held for 30 cycles after its press → 1 + 5 reads issued; releasing the button stops repeats.
